// File: rtl/fc_wr_burst_ctrl_pkg.sv
// Shared definitions for the fully-connected result write-back controller.
//   FC_AWID     : default user id driven on the AW channel
//   fc_state_e  : burst FSM states
//   ceil_div()  : integer ceiling division, used to size the burst count
package fc_pkg;

    localparam logic [3:0] FC_AWID = 4'b0110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AW   = 3'd1,
        ST_W    = 3'd2,
        ST_B    = 3'd3,
        ST_DONE = 3'd4
    } fc_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/fc_wr_burst_ctrl_if.sv
// Write bus between the result write-back controller and the system bus.
//   AW : awvalid/awready, awaddr, awlen (beats-1), awuser_id, awuser_ap
//   W  : wvalid/wready, wdata, wstrb, wlast
//   B  : bvalid/bready
// master = controller side, slave = bus side.
interface fc_wr_burst_ctrl_if #(
    parameter int ADDR_W = 28
);
    logic              NwcBus_awvalid;
    logic              BusNwc_awready;
    logic [ADDR_W-1:0] NwcBus_awaddr;
    logic [3:0]        NwcBus_awlen;
    logic [3:0]        NwcBus_awuser_id;
    logic              NwcBus_awuser_ap;
    logic              NwcBus_wvalid;
    logic              BusNwc_wready;
    logic [31:0]       NwcBus_wdata;
    logic [3:0]        NwcBus_wstrb;
    logic              NwcBus_wlast;
    logic              BusNwc_bvalid;
    logic              NwcBus_bready;

    modport master (
        output NwcBus_awvalid, NwcBus_awaddr, NwcBus_awlen, NwcBus_awuser_id,
               NwcBus_awuser_ap, NwcBus_wvalid, NwcBus_wdata, NwcBus_wstrb,
               NwcBus_wlast, NwcBus_bready,
        input  BusNwc_awready, BusNwc_wready, BusNwc_bvalid
    );

    modport slave (
        input  NwcBus_awvalid, NwcBus_awaddr, NwcBus_awlen, NwcBus_awuser_id,
               NwcBus_awuser_ap, NwcBus_wvalid, NwcBus_wdata, NwcBus_wstrb,
               NwcBus_wlast, NwcBus_bready,
        output BusNwc_awready, BusNwc_wready, BusNwc_bvalid
    );

endinterface

// File: rtl/fc_wr_word_sel.sv
// Combinational word selector: returns 32-bit word k of the captured result
// vector (word k sits at bits [k*32 +: 32]). Out-of-range k returns zero.
//   vec  : N*32-bit captured vector
//   k    : word index
//   word : selected word
module fc_wr_word_sel #(
    parameter int N  = 10,
    parameter int KW = 4
) (
    input  logic [N*32-1:0] vec,
    input  logic [KW-1:0]   k,
    output logic [31:0]     word
);

    // Indexed word extraction with a zero fallback past the end of the vector.
    always_comb begin
        word = 32'd0;
        if (int'(k) < N) begin
            word = vec[int'(k)*32 +: 32];
        end else begin
            word = 32'd0;
        end
    end

endmodule

// File: rtl/fc_wr_burst_ctrl.sv
// Result write-back controller for the fully-connected layer. Captures a
// BATCH_SIZE x BIAS_SIZE vector of 32-bit results and writes it out as
// address-incrementing bursts of up to BURST_LEN beats, one burst at a time
// (AW, then all W beats, then B).
//   clk, rst_n        : clock, asynchronous active-low reset
//   FcNwc_result_en   : strobe, result vector valid (honoured only when idle)
//   FcNwc_result      : packed [BATCH][BIAS][31:0] results
//   NcNwc_initAddr/En : base byte address and its load strobe
//   NwcNc_done        : one-cycle completion pulse after the last response
//   NwcFc_busy        : job in progress
//   bus               : AW/W/B write channels (master side)
// All outputs are registered: they are decoded from next-state values.
module fc_wr_burst_ctrl
    import fc_pkg::*;
#(
    parameter int         BATCH_SIZE = 1,
    parameter int         BIAS_SIZE  = 10,
    parameter int         BURST_LEN  = 16,
    parameter int         ADDR_W     = 28,
    parameter logic [3:0] AWID       = FC_AWID
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            FcNwc_result_en,
    input  logic [BATCH_SIZE*BIAS_SIZE*32-1:0] FcNwc_result,
    input  logic [ADDR_W-1:0]               NcNwc_initAddr,
    input  logic                            NcNwc_initAddrEn,
    output logic                            NwcNc_done,
    output logic                            NwcFc_busy,
    fc_wr_burst_ctrl_if.master              bus
);

    localparam int N    = BATCH_SIZE * BIAS_SIZE;
    localparam int NB   = ceil_div(N, BURST_LEN);
    localparam int LAST = N - (NB - 1) * BURST_LEN;
    localparam int KW   = $clog2(N + 1);
    localparam int BW   = (NB > 1) ? $clog2(NB) : 1;

    generate
        if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
            $error("fc_wr_burst_ctrl: BURST_LEN must be within 1..16");
        end
    endgenerate

    fc_state_e         state_r, state_s;
    logic [BW-1:0]     burst_r, burst_s;
    logic [4:0]        beat_r, beat_s;
    logic [KW-1:0]     k_r, k_s;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] job_base_r, job_base_s;
    logic [N*32-1:0]   buf_r, buf_s;
    logic [4:0]        len_cur_s, len_nxt_s;
    logic [31:0]       word_s;

    logic              awvalid_s, wvalid_s, wlast_s, bready_s, done_s, busy_s;
    logic [ADDR_W-1:0] awaddr_s;
    logic [3:0]        awlen_s, wstrb_s;
    logic [31:0]       wdata_s;

    // Beats in the current burst and in the burst selected for next cycle;
    // only the final burst may be short.
    always_comb begin
        len_cur_s = (burst_r == BW'(NB - 1)) ? 5'(LAST) : 5'(BURST_LEN);
        len_nxt_s = (burst_s == BW'(NB - 1)) ? 5'(LAST) : 5'(BURST_LEN);
    end

    // Next-state, counter and capture logic. Handshakes use the registered
    // valid, which is high exactly when the FSM sits in the matching state.
    always_comb begin
        state_s    = state_r;
        burst_s    = burst_r;
        beat_s     = beat_r;
        k_s        = k_r;
        job_base_s = job_base_r;
        buf_s      = buf_r;
        case (state_r)
            ST_IDLE: begin
                if (FcNwc_result_en) begin
                    buf_s      = FcNwc_result;
                    // A coincident base load applies to the job being captured.
                    job_base_s = NcNwc_initAddrEn ? NcNwc_initAddr : base_r;
                    burst_s    = {BW{1'b0}};
                    beat_s     = 5'd0;
                    k_s        = {KW{1'b0}};
                    state_s    = ST_AW;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_AW: begin
                if (bus.BusNwc_awready) begin
                    state_s = ST_W;
                end else begin
                    state_s = ST_AW;
                end
            end
            ST_W: begin
                if (bus.BusNwc_wready) begin
                    k_s = k_r + KW'(1);
                    if (beat_r == len_cur_s - 5'd1) begin
                        beat_s  = 5'd0;
                        state_s = ST_B;
                    end else begin
                        beat_s  = beat_r + 5'd1;
                        state_s = ST_W;
                    end
                end else begin
                    state_s = ST_W;
                end
            end
            ST_B: begin
                if (bus.BusNwc_bvalid) begin
                    if (burst_r != BW'(NB - 1)) begin
                        burst_s = burst_r + BW'(1);
                        state_s = ST_AW;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_B;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    fc_wr_word_sel #(
        .N  (N),
        .KW (KW)
    ) u_word_sel (
        .vec  (buf_s),
        .k    (k_s),
        .word (word_s)
    );

    // Output decode from next-state values so the output registers line up
    // with the state register.
    always_comb begin
        awvalid_s = 1'b0;
        awaddr_s  = {ADDR_W{1'b0}};
        awlen_s   = 4'd0;
        wvalid_s  = 1'b0;
        wdata_s   = 32'd0;
        wstrb_s   = 4'h0;
        wlast_s   = 1'b0;
        if (state_s == ST_AW) begin
            awvalid_s = 1'b1;
            // Address wraps modulo 2^ADDR_W by truncation.
            awaddr_s  = job_base_s + ADDR_W'(burst_s) * ADDR_W'(BURST_LEN * 4);
            awlen_s   = 4'(len_nxt_s - 5'd1);
        end else begin
            awvalid_s = 1'b0;
        end
        if (state_s == ST_W) begin
            wvalid_s = 1'b1;
            wdata_s  = word_s;
            wstrb_s  = 4'hF;
            wlast_s  = (beat_s == len_nxt_s - 5'd1);
        end else begin
            wvalid_s = 1'b0;
        end
        bready_s = (state_s == ST_B);
        done_s   = (state_s == ST_DONE);
        busy_s   = (state_s == ST_AW) || (state_s == ST_W) || (state_s == ST_B);
    end

    // State, counters, job base and result buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            burst_r    <= {BW{1'b0}};
            beat_r     <= 5'd0;
            k_r        <= {KW{1'b0}};
            job_base_r <= {ADDR_W{1'b0}};
            buf_r      <= {(N*32){1'b0}};
        end else begin
            state_r    <= state_s;
            burst_r    <= burst_s;
            beat_r     <= beat_s;
            k_r        <= k_s;
            job_base_r <= job_base_s;
            buf_r      <= buf_s;
        end
    end

    // Base register loads in any state; a running job keeps its own copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= {ADDR_W{1'b0}};
        end else if (NcNwc_initAddrEn) begin
            base_r <= NcNwc_initAddr;
        end else begin
            base_r <= base_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.NwcBus_awvalid   <= 1'b0;
            bus.NwcBus_awaddr    <= {ADDR_W{1'b0}};
            bus.NwcBus_awlen     <= 4'd0;
            bus.NwcBus_awuser_id <= 4'd0;
            bus.NwcBus_awuser_ap <= 1'b0;
            bus.NwcBus_wvalid    <= 1'b0;
            bus.NwcBus_wdata     <= 32'd0;
            bus.NwcBus_wstrb     <= 4'h0;
            bus.NwcBus_wlast     <= 1'b0;
            bus.NwcBus_bready    <= 1'b0;
            NwcNc_done           <= 1'b0;
            NwcFc_busy           <= 1'b0;
        end else begin
            bus.NwcBus_awvalid   <= awvalid_s;
            bus.NwcBus_awaddr    <= awaddr_s;
            bus.NwcBus_awlen     <= awlen_s;
            bus.NwcBus_awuser_id <= AWID;
            bus.NwcBus_awuser_ap <= awvalid_s;
            bus.NwcBus_wvalid    <= wvalid_s;
            bus.NwcBus_wdata     <= wdata_s;
            bus.NwcBus_wstrb     <= wstrb_s;
            bus.NwcBus_wlast     <= wlast_s;
            bus.NwcBus_bready    <= bready_s;
            NwcNc_done           <= done_s;
            NwcFc_busy           <= busy_s;
        end
    end

endmodule

// File: tb/tb_fc_wr_burst_ctrl.sv
// Self-checking bench for fc_wr_burst_ctrl. Three instances share clock,
// reset, base-address and ready inputs:
//   dut_a : 1 x 10, BURST_LEN 16
//   dut_b : 4 x 10, BURST_LEN 16
//   dut_c : 1 x 3,  BURST_LEN 1
// A vector table covers the cycle-exact zero-backpressure sequences; a
// monitor task covers the multi-cycle corner cases.
module tb_fc_wr_burst_ctrl;

    localparam int NA = 10;
    localparam int NBV = 40;
    localparam int NC = 3;

    typedef struct packed {
        logic        awvalid;
        logic [27:0] awaddr;
        logic [3:0]  awlen;
        logic [3:0]  awid;
        logic        awap;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
        logic        done;
        logic        busy;
    } obs_t;

    typedef struct {
        int          sel;
        bit          ren;
        bit          aen;
        logic [27:0] addr;
        obs_t        exp;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [27:0]     init_addr;
    logic            init_addr_en;
    logic            awready, wready, bvalid;
    logic            ren_a, ren_b, ren_c;
    logic [NA*32-1:0]  res_a;
    logic [NBV*32-1:0] res_b;
    logic [NC*32-1:0]  res_c;
    logic            done_a, busy_a, done_b, busy_b, done_c, busy_c;

    fc_wr_burst_ctrl_if #(.ADDR_W(28)) if_a ();
    fc_wr_burst_ctrl_if #(.ADDR_W(28)) if_b ();
    fc_wr_burst_ctrl_if #(.ADDR_W(28)) if_c ();

    assign if_a.BusNwc_awready = awready;
    assign if_a.BusNwc_wready  = wready;
    assign if_a.BusNwc_bvalid  = bvalid;
    assign if_b.BusNwc_awready = awready;
    assign if_b.BusNwc_wready  = wready;
    assign if_b.BusNwc_bvalid  = bvalid;
    assign if_c.BusNwc_awready = awready;
    assign if_c.BusNwc_wready  = wready;
    assign if_c.BusNwc_bvalid  = bvalid;

    fc_wr_burst_ctrl #(.BATCH_SIZE(1), .BIAS_SIZE(10), .BURST_LEN(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .FcNwc_result_en(ren_a), .FcNwc_result(res_a),
        .NcNwc_initAddr(init_addr), .NcNwc_initAddrEn(init_addr_en),
        .NwcNc_done(done_a), .NwcFc_busy(busy_a), .bus(if_a));
    fc_wr_burst_ctrl #(.BATCH_SIZE(4), .BIAS_SIZE(10), .BURST_LEN(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .FcNwc_result_en(ren_b), .FcNwc_result(res_b),
        .NcNwc_initAddr(init_addr), .NcNwc_initAddrEn(init_addr_en),
        .NwcNc_done(done_b), .NwcFc_busy(busy_b), .bus(if_b));
    fc_wr_burst_ctrl #(.BATCH_SIZE(1), .BIAS_SIZE(3), .BURST_LEN(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .FcNwc_result_en(ren_c), .FcNwc_result(res_c),
        .NcNwc_initAddr(init_addr), .NcNwc_initAddrEn(init_addr_en),
        .NwcNc_done(done_c), .NwcFc_busy(busy_c), .bus(if_c));

    obs_t ob_a, ob_b, ob_c, v;
    int   sel;

    assign ob_a = {if_a.NwcBus_awvalid, if_a.NwcBus_awaddr, if_a.NwcBus_awlen, if_a.NwcBus_awuser_id,
                   if_a.NwcBus_awuser_ap, if_a.NwcBus_wvalid, if_a.NwcBus_wdata, if_a.NwcBus_wstrb,
                   if_a.NwcBus_wlast, if_a.NwcBus_bready, done_a, busy_a};
    assign ob_b = {if_b.NwcBus_awvalid, if_b.NwcBus_awaddr, if_b.NwcBus_awlen, if_b.NwcBus_awuser_id,
                   if_b.NwcBus_awuser_ap, if_b.NwcBus_wvalid, if_b.NwcBus_wdata, if_b.NwcBus_wstrb,
                   if_b.NwcBus_wlast, if_b.NwcBus_bready, done_b, busy_b};
    assign ob_c = {if_c.NwcBus_awvalid, if_c.NwcBus_awaddr, if_c.NwcBus_awlen, if_c.NwcBus_awuser_id,
                   if_c.NwcBus_awuser_ap, if_c.NwcBus_wvalid, if_c.NwcBus_wdata, if_c.NwcBus_wstrb,
                   if_c.NwcBus_wlast, if_c.NwcBus_bready, done_c, busy_c};

    always_comb begin
        case (sel)
            0:       v = ob_a;
            1:       v = ob_b;
            default: v = ob_c;
        endcase
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_word [0:63];
    vec_t        tbl [$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] wgen(input int seed, input int k);
        return (32'(seed) << 24) ^ (32'(k) * 32'h0001_0203) ^ 32'h005A_0000;
    endfunction

    // Expected observation for a phase: 0 idle, 1 AW, 2 W, 3 B, 4 done.
    function automatic vec_t mk(input int s, input bit ren, input bit aen, input logic [27:0] addr,
                                input int st, input logic [27:0] a, input logic [3:0] l,
                                input logic [31:0] d, input bit last);
        vec_t r;
        r.sel = s; r.ren = ren; r.aen = aen; r.addr = addr;
        r.exp = '0;
        if (st == 1) begin
            r.exp.awvalid = 1'b1; r.exp.awaddr = a; r.exp.awlen = l;
            r.exp.awid = 4'b0110; r.exp.awap = 1'b1;
        end
        if (st == 2) begin
            r.exp.wvalid = 1'b1; r.exp.wdata = d; r.exp.wstrb = 4'hF; r.exp.wlast = last;
        end
        r.exp.bready = (st == 3);
        r.exp.done   = (st == 4);
        r.exp.busy   = (st >= 1 && st <= 3);
        return r;
    endfunction

    // Payload fields only matter while their valid is high.
    function automatic obs_t mask(input obs_t o);
        obs_t r = o;
        if (!o.awvalid) begin
            r.awaddr = 28'd0; r.awlen = 4'd0; r.awid = 4'd0; r.awap = 1'b0;
        end
        if (!o.wvalid) begin
            r.wdata = 32'd0; r.wlast = 1'b0;
        end
        return r;
    endfunction

    task automatic set_ren(input int s, input bit val);
        ren_a = (s == 0) && val;
        ren_b = (s == 1) && val;
        ren_c = (s == 2) && val;
    endtask

    task automatic load_base(input logic [27:0] a);
        @(negedge clk);
        init_addr = a; init_addr_en = 1'b1;
        @(negedge clk);
        init_addr_en = 1'b0;
    endtask

    // Starts a job on instance s and follows it to the done pulse, checking
    // every AW request, every W beat and the done timing along the way.
    task automatic run_job(input int s, input int nbeats, input int blen, input logic [27:0] base,
                           input int aw_stall, input bit w_toggle, input bit mid_job,
                           input int abort_beat, input string tag);
        int nb = (nbeats + blen - 1) / blen;
        int lastl = nbeats - (nb - 1) * blen;
        int k = 0, aw_hs = 0, b_hs = 0, dones = 0, cyc = 0, stall = 0, beat = 0, wcyc = 0;
        int last_b = -10, len = 0;
        bit aborted = 1'b0;
        sel = s;
        @(negedge clk);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
        set_ren(s, 1'b1);
        while (dones == 0 && cyc < 600 && !aborted) begin
            @(negedge clk);
            cyc++;
            set_ren(s, 1'b0);
            init_addr_en = 1'b0;
            if (mid_job && cyc == 4) begin
                for (int i = 0; i < NA; i++) res_a[i*32 +: 32] = wgen(9, i);
                init_addr = 28'h200; init_addr_en = 1'b1;
                set_ren(s, 1'b1);
            end
            awready = 1'b1;
            if (v.awvalid && aw_hs == 0 && stall < aw_stall) begin
                awready = 1'b0; stall++;
            end
            wready = w_toggle ? (wcyc % 2 == 0) : 1'b1;
            if (v.wvalid) wcyc++;
            bvalid = 1'b1;
            if (abort_beat >= 0 && v.wvalid && k == abort_beat) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_reset_outputs"}, {ob_a, ob_b, ob_c}, 256'd0);
                aborted = 1'b1;
            end else begin
                if (v.awvalid) begin
                    len = (aw_hs == nb - 1) ? lastl : blen;
                    chk({tag, "_aw"}, {v.awaddr, v.awlen, v.awid, v.awap},
                        {base + 28'(aw_hs * blen * 4), 4'(len - 1), 4'b0110, 1'b1});
                    if (awready) begin aw_hs++; beat = 0; end
                end
                if (v.wvalid) begin
                    len = (aw_hs - 1 == nb - 1) ? lastl : blen;
                    chk({tag, "_w"}, {v.wdata, v.wstrb, v.wlast}, {exp_word[k], 4'hF, (beat == len - 1)});
                    if (wready) begin k++; beat++; end
                end
                if (v.bready && bvalid) begin b_hs++; last_b = cyc; end
                if (v.done) begin
                    dones++;
                    chk({tag, "_done"}, {k, aw_hs, b_hs, cyc - last_b, 31'd0, v.busy},
                        {nbeats, nb, nb, 32'd1, 32'd0});
                end
            end
        end
        if (!aborted) begin
            if (dones == 0) chk({tag, "_timeout"}, 256'(dones), 256'd1);
            @(negedge clk);
            chk({tag, "_after_done"}, {v.done, v.busy, v.awvalid, v.wvalid}, 4'd0);
        end
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; init_addr = 28'd0; init_addr_en = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        ren_a = 1'b0; ren_b = 1'b0; ren_c = 1'b0; sel = 0;
        for (int i = 0; i < NA; i++) res_a[i*32 +: 32] = wgen(1, i);
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 10; i++) res_b[(b*10 + i)*32 +: 32] = wgen(2, b*100 + i);
        for (int i = 0; i < NC; i++) res_c[i*32 +: 32] = wgen(3, i);

        repeat (2) @(negedge clk);
        chk("reset_a", ob_a, 256'd0);
        chk("reset_b", ob_b, 256'd0);
        chk("reset_c", ob_c, 256'd0);
        rst_n = 1'b1;

        // dut_c: base loaded together with result_en, three one-beat bursts.
        tbl.push_back(mk(2, 1, 1, 28'h40, 1, 28'h40, 4'd0, 32'd0, 0));
        tbl.push_back(mk(2, 0, 0, 28'h0, 2, 28'h0, 4'd0, wgen(3, 0), 1));
        tbl.push_back(mk(2, 0, 0, 28'h0, 3, 28'h0, 4'd0, 32'd0, 0));
        tbl.push_back(mk(2, 0, 0, 28'h0, 1, 28'h44, 4'd0, 32'd0, 0));
        tbl.push_back(mk(2, 0, 0, 28'h0, 2, 28'h0, 4'd0, wgen(3, 1), 1));
        tbl.push_back(mk(2, 0, 0, 28'h0, 3, 28'h0, 4'd0, 32'd0, 0));
        tbl.push_back(mk(2, 0, 0, 28'h0, 1, 28'h48, 4'd0, 32'd0, 0));
        tbl.push_back(mk(2, 0, 0, 28'h0, 2, 28'h0, 4'd0, wgen(3, 2), 1));
        tbl.push_back(mk(2, 0, 0, 28'h0, 3, 28'h0, 4'd0, 32'd0, 0));
        tbl.push_back(mk(2, 0, 0, 28'h0, 4, 28'h0, 4'd0, 32'd0, 0));
        tbl.push_back(mk(2, 0, 0, 28'h0, 0, 28'h0, 4'd0, 32'd0, 0));
        // dut_a: base 0x100 loaded first, one 10-beat burst.
        tbl.push_back(mk(0, 0, 1, 28'h100, 0, 28'h0, 4'd0, 32'd0, 0));
        tbl.push_back(mk(0, 1, 0, 28'h0, 1, 28'h100, 4'd9, 32'd0, 0));
        for (int i = 0; i < NA; i++) tbl.push_back(mk(0, 0, 0, 28'h0, 2, 28'h0, 4'd0, wgen(1, i), i == 9));
        tbl.push_back(mk(0, 0, 0, 28'h0, 3, 28'h0, 4'd0, 32'd0, 0));
        tbl.push_back(mk(0, 0, 0, 28'h0, 4, 28'h0, 4'd0, 32'd0, 0));
        tbl.push_back(mk(0, 0, 0, 28'h0, 0, 28'h0, 4'd0, 32'd0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            sel = tbl[i].sel;
            set_ren(tbl[i].sel, tbl[i].ren);
            init_addr_en = tbl[i].aen; init_addr = tbl[i].addr;
            awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), mask(v), tbl[i].exp);
        end
        @(negedge clk);
        set_ren(0, 1'b0); init_addr_en = 1'b0;

        // dut_b: three bursts crossing a 16 MiB boundary, short last burst.
        for (int i = 0; i < NBV; i++) exp_word[i] = res_b[i*32 +: 32];
        load_base(28'h0FFFFF0);
        run_job(1, 40, 16, 28'h0FFFFF0, 0, 1'b0, 1'b0, -1, "b4x10");

        // dut_c: address wraps modulo 2^28.
        for (int i = 0; i < NC; i++) exp_word[i] = wgen(3, i);
        load_base(28'hFFFFFFC);
        run_job(2, 3, 1, 28'hFFFFFFC, 0, 1'b0, 1'b0, -1, "c_wrap");

        // dut_a: AW stalled five cycles, then wready toggling 1010.
        for (int i = 0; i < NA; i++) exp_word[i] = wgen(1, i);
        load_base(28'h100);
        run_job(0, 10, 16, 28'h100, 5, 1'b1, 1'b0, -1, "backpressure");

        // dut_a: new data, result_en and base 0x200 arrive mid-job.
        load_base(28'h300);
        run_job(0, 10, 16, 28'h300, 0, 1'b0, 1'b1, -1, "midjob");
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (v.busy || v.awvalid) cnt++;
        end
        chk("midjob_no_queue", 256'(cnt), 256'd0);
        for (int i = 0; i < NA; i++) exp_word[i] = wgen(9, i);
        run_job(0, 10, 16, 28'h200, 0, 1'b0, 1'b0, -1, "next_job");

        // dut_a: reset during beat 5, then a clean job.
        run_job(0, 10, 16, 28'h200, 0, 1'b0, 1'b0, 5, "abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        set_ren(0, 1'b0);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (v.done || v.busy) cnt++;
        end
        chk("post_reset_idle", 256'(cnt), 256'd0);
        load_base(28'h500);
        run_job(0, 10, 16, 28'h500, 0, 1'b0, 1'b0, -1, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
